// File: rtl/ahb_interconnect_n.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_interconnect_n
//  Purpose  : AHB-Lite single-master interconnect. Decodes HADDR into one-hot
//             slave selects, carries the address-phase selection into the
//             data phase and multiplexes the selected slave's HRDATA /
//             HREADYOUT / HRESP back to the master. Accesses to unmapped
//             regions are answered by a built-in default slave with the
//             two-cycle AHB ERROR response. Includes a saturating count of
//             ERROR responses and an optional hung-slave watchdog.
//  Options  : `define AHB_IC_WATCHDOG_EN to build the watchdog; otherwise
//             timeout_flag is tied low and slaves may stall indefinitely.
//  Ports    : HCLK, HRESET (sync, active-high)
//             HADDR, HTRANS            - master address phase
//             HSEL_S                   - one-hot slave selects (combinational)
//             HRDATA_S/HREADYOUT_S/HRESP_S - per-slave data-phase returns
//             HRDATA/HREADY/HRESP      - data-phase return to the master
//                                        (HREADY is also every slave's HREADYIN)
//             err_count                - saturating ERROR response count
//             timeout_flag             - sticky watchdog expiry flag
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_interconnect_n #(
    parameter int NUM_SLAVES     = 4,
    parameter int DATA_W         = 32,
    parameter int SEL_LSB        = 16,
    parameter int SEL_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    output logic [NUM_SLAVES-1:0]        HSEL_S,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [7:0]                   err_count,
    output logic                         timeout_flag
);

    // Default-slave state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ERR1 = 2'd1;
    localparam logic [1:0] S_ERR2 = 2'd2;

    logic [SEL_BITS-1:0] idx;
    logic                unmapped;
    logic [SEL_BITS-1:0] dp_idx;
    logic                dp_valid;
    logic                dp_unmapped;
    logic                slave_active;
    logic [DATA_W-1:0]   sel_rdata;
    logic                sel_ready;
    logic                sel_resp;
    logic [1:0]          state;
    logic [1:0]          state_next;
    logic                wd_hit;

    // Only the index field and HTRANS[1] matter; the rest is deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{HADDR, HTRANS[0]};

    // ------------------------------------------------------------------
    // Address decode (combinational, independent of HTRANS and reset)
    // ------------------------------------------------------------------
    assign idx      = HADDR[SEL_LSB+SEL_BITS-1:SEL_LSB];
    assign unmapped = (int'(idx) >= NUM_SLAVES);

    always_comb begin
        HSEL_S = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            HSEL_S[i] = (int'(idx) == i);
        end
    end

    // ------------------------------------------------------------------
    // Data-phase selection: advances only when the bus is ready, so a
    // slave's wait states hold the selection for their whole duration.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_idx      <= '0;
            dp_valid    <= 1'b0;
            dp_unmapped <= 1'b0;
        end else if (HREADY) begin
            dp_idx      <= idx;
            dp_valid    <= HTRANS[1];
            dp_unmapped <= unmapped;
        end
    end

    assign slave_active = dp_valid && !dp_unmapped;

    // Return mux; the loop form keeps the index compare width-safe when
    // NUM_SLAVES is not a power of two.
    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b1;
        sel_resp  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(dp_idx) == i) begin
                sel_rdata = HRDATA_S[i*DATA_W +: DATA_W];
                sel_ready = HREADYOUT_S[i];
                sel_resp  = HRESP_S[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Default slave FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. ERR2 drives HREADY=1, so an unmapped NONSEQ/SEQ seen
    // there is accepted and chains straight into the next ERR1.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (wd_hit || (HREADY && HTRANS[1] && unmapped)) begin
                    state_next = S_ERR1;
                end
            end
            S_ERR1:  state_next = S_ERR2;
            S_ERR2:  state_next = (HTRANS[1] && unmapped) ? S_ERR1 : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs: the default slave overrides the attached slave while it
    // is issuing an ERROR (including a watchdog-forced one).
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        case (state)
            S_IDLE: begin
                if (slave_active) begin
                    HRDATA = sel_rdata;
                    HREADY = sel_ready;
                    HRESP  = sel_resp;
                end
            end
            S_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            S_ERR2: begin
                HRESP = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ERROR response counter: one count per completed ERROR beat
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_count <= 8'd0;
        end else if (HREADY && HRESP && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Optional hung-slave watchdog
    // ------------------------------------------------------------------
`ifdef AHB_IC_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        stall;

    assign stall  = (state == S_IDLE) && slave_active && !sel_ready;
    // Fires during the TIMEOUT_CYCLES-th consecutive stall cycle so ERR1
    // follows immediately after it.
    assign wd_hit = stall && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wd_cnt       <= 16'd0;
            timeout_flag <= 1'b0;
        end else begin
            if (HREADY) begin
                wd_cnt <= 16'd0;
            end else if (stall) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (wd_hit) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign wd_hit       = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_interconnect_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_interconnect_n
//  Purpose  : Self-checking bench for ahb_interconnect_n (3 slaves, 2-bit
//             index field, 16-cycle watchdog limit). Expected data-phase
//             results are queued when an address phase is accepted and
//             compared when the data phase completes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_interconnect_n;

    localparam int NS = 3;
    localparam int DW = 32;

    logic            hclk;
    logic            hreset;
    logic [31:0]     haddr;
    logic [1:0]      htrans;
    logic [NS-1:0]   hsel_s;
    logic [NS*DW-1:0] hrdata_s;
    logic [NS-1:0]   hreadyout_s;
    logic [NS-1:0]   hresp_s;
    logic [DW-1:0]   hrdata;
    logic            hready;
    logic            hresp;
    logic [7:0]      err_count;
    logic            timeout_flag;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    ahb_interconnect_n #(
        .NUM_SLAVES    (NS),
        .DATA_W        (DW),
        .SEL_LSB       (16),
        .SEL_BITS      (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .HCLK        (hclk),
        .HRESET      (hreset),
        .HADDR       (haddr),
        .HTRANS      (htrans),
        .HSEL_S      (hsel_s),
        .HRDATA_S    (hrdata_s),
        .HREADYOUT_S (hreadyout_s),
        .HRESP_S     (hresp_s),
        .HRDATA      (hrdata),
        .HREADY      (hready),
        .HRESP       (hresp),
        .err_count   (err_count),
        .timeout_flag(timeout_flag)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Fixed, distinct read data per slave
    assign hrdata_s = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] data;
        logic        resp;
    } exp_t;

    exp_t        sb[$];
    logic [NS-1:0] slv_err   = '0;   // slaves programmed to answer ERROR
    logic        wd_expect = 1'b0; // next accepted transfer will time out

    function automatic exp_t model(input logic [31:0] a);
        exp_t       e;
        logic [1:0] i;
        i = a[17:16];
        if (wd_expect) begin
            e.data = 32'h0;
            e.resp = 1'b1;
        end else if (i < 2'd3) begin
            e.data = 32'hA5A5_0000 | 32'(i);
            e.resp = slv_err[i];
        end else begin
            e.data = 32'h0;
            e.resp = 1'b1;
        end
        return e;
    endfunction

    // Completion first (pops the previous transfer), then acceptance of
    // the current address phase.
    always @(negedge hclk) begin
        exp_t e;
        if (hreset) begin
            sb.delete();
        end else if (hready) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("dp_rdata", hrdata, e.data);
                check("dp_resp", 32'(hresp), 32'(e.resp));
            end else begin
                check("idle_resp", 32'(hresp), 32'h0);
                check("idle_rdata", hrdata, 32'h0);
            end
            if (htrans[1]) sb.push_back(model(haddr));
        end
    end

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic mid();
        @(negedge hclk);
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        haddr  = a;
        htrans = t;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        hreset      = 1'b1;
        hreadyout_s = '1;
        hresp_s     = '0;
        drive(32'h0001_0004, T_IDLE);

        // ---------------- reset state ----------------
        repeat (3) next_cycle();
        mid();
        check("rst_hready", 32'(hready), 32'h1);
        check("rst_hresp", 32'(hresp), 32'h0);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_err", 32'(err_count), 32'h0);
        check("rst_tflag", 32'(timeout_flag), 32'h0);
        check("rst_hsel", 32'(hsel_s), 32'h2);
        next_cycle();
        hreset = 1'b0;

        // ---------------- single read from slave 1 ----------------
        drive(32'h0001_0004, T_NONSEQ);
        mid();
        check("rd1_hsel", 32'(hsel_s), 32'h2);
        next_cycle();
        drive(32'h0000_0000, T_IDLE);
        mid();
        check("rd1_hready", 32'(hready), 32'h1);

        // ---------------- slave 2 wait states ----------------
        next_cycle();
        drive(32'h0002_0000, T_NONSEQ);
        mid();
        check("ws_hsel_addr", 32'(hsel_s), 32'h4);
        next_cycle();
        drive(32'h0000_0000, T_NONSEQ);
        hreadyout_s[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            check("ws_hsel_hold", 32'(hsel_s), 32'h1);
            check("ws_hready", 32'(hready), 32'h0);
            if (k < 2) next_cycle();
        end
        next_cycle();
        hreadyout_s[2] = 1'b1;
        mid();
        check("ws_release", 32'(hready), 32'h1);
        next_cycle();
        drive(32'h0000_0000, T_IDLE);
        mid();

        // ---------------- unmapped NONSEQ ----------------
        next_cycle();
        drive(32'h0003_0000, T_NONSEQ);
        mid();
        check("um_hsel", 32'(hsel_s), 32'h0);
        next_cycle();
        drive(32'h0000_0000, T_IDLE);
        mid();
        check("err1_hready", 32'(hready), 32'h0);
        check("err1_hresp", 32'(hresp), 32'h1);
        next_cycle();
        mid();
        check("err2_hready", 32'(hready), 32'h1);
        check("err2_hresp", 32'(hresp), 32'h1);
        next_cycle();
        mid();
        check("um_err_count", 32'(err_count), 32'd1);

        // ---------------- IDLE to unmapped ----------------
        drive(32'h0003_0000, T_IDLE);
        mid();
        check("idle_um_hready", 32'(hready), 32'h1);
        next_cycle();
        mid();
        check("idle_um_hready2", 32'(hready), 32'h1);
        check("idle_um_hresp2", 32'(hresp), 32'h0);
        check("idle_um_err", 32'(err_count), 32'd1);

        // ---------------- back-to-back unmapped (ERR2 -> ERR1) ----------------
        next_cycle();
        drive(32'h0003_0000, T_NONSEQ);
        next_cycle();
        drive(32'h0003_0004, T_NONSEQ);
        mid();
        check("b2b_err1_hready", 32'(hready), 32'h0);
        next_cycle();
        mid();
        check("b2b_err2_hresp", 32'(hresp), 32'h1);
        next_cycle();
        drive(32'h0000_0000, T_IDLE);
        mid();
        check("b2b_err1b_hready", 32'(hready), 32'h0);
        check("b2b_err1b_hresp", 32'(hresp), 32'h1);
        next_cycle();
        mid();
        check("b2b_err2b_hready", 32'(hready), 32'h1);
        next_cycle();
        mid();
        check("b2b_err_count", 32'(err_count), 32'd3);

        // ---------------- upper address bits ignored ----------------
        drive(32'hFFF2_0008, T_NONSEQ);
        mid();
        check("upper_hsel", 32'(hsel_s), 32'h4);
        next_cycle();
        drive(32'h0000_0000, T_IDLE);
        mid();

        // ---------------- slave-sourced ERROR ----------------
        next_cycle();
        slv_err[0] = 1'b1;
        drive(32'h0000_0010, T_NONSEQ);
        mid();
        next_cycle();
        drive(32'h0000_0000, T_IDLE);
        hreadyout_s[0] = 1'b0;
        hresp_s[0]     = 1'b1;
        mid();
        check("serr1_hready", 32'(hready), 32'h0);
        check("serr1_hresp", 32'(hresp), 32'h1);
        next_cycle();
        hreadyout_s[0] = 1'b1;
        mid();
        next_cycle();
        hresp_s[0] = 1'b0;
        slv_err[0] = 1'b0;
        mid();
        check("serr_err_count", 32'(err_count), 32'd4);

        // ---------------- counter saturation ----------------
        next_cycle();
        drive(32'h0003_0000, T_NONSEQ);
        repeat (520) next_cycle();
        drive(32'h0000_0000, T_IDLE);
        repeat (3) next_cycle();
        mid();
        check("sat_err_count", 32'(err_count), 32'd255);

        // ---------------- reset in ERR1 ----------------
        next_cycle();
        drive(32'h0003_0000, T_NONSEQ);
        mid();
        next_cycle();
        drive(32'h0000_0000, T_IDLE);
        mid();
        check("rerr_err1_hready", 32'(hready), 32'h0);
        hreset = 1'b1;
        next_cycle();
        mid();
        check("rerr_hready", 32'(hready), 32'h1);
        check("rerr_hresp", 32'(hresp), 32'h0);
        check("rerr_err_count", 32'(err_count), 32'd0);
        next_cycle();
        hreset = 1'b0;
        next_cycle();
        mid();
        check("rerr_after_hready", 32'(hready), 32'h1);

        // ---------------- hung slave 1 ----------------
        next_cycle();
`ifdef AHB_IC_WATCHDOG_EN
        wd_expect = 1'b1;
        drive(32'h0001_0000, T_NONSEQ);
        mid();
        next_cycle();
        wd_expect = 1'b0;
        drive(32'h0000_0000, T_IDLE);
        hreadyout_s[1] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mid();
            check("wd_stall_hready", 32'(hready), 32'h0);
            check("wd_stall_hresp", 32'(hresp), 32'h0);
            next_cycle();
        end
        mid();
        check("wd_err1_hready", 32'(hready), 32'h0);
        check("wd_err1_hresp", 32'(hresp), 32'h1);
        check("wd_tflag", 32'(timeout_flag), 32'h1);
        next_cycle();
        mid();
        check("wd_err2_hready", 32'(hready), 32'h1);
        check("wd_err2_hresp", 32'(hresp), 32'h1);
        next_cycle();
        mid();
        check("wd_err_count", 32'(err_count), 32'd1);
        check("wd_tflag_sticky", 32'(timeout_flag), 32'h1);
        next_cycle();
        hreadyout_s[1] = 1'b1;
        mid();
`else
        drive(32'h0001_0000, T_NONSEQ);
        mid();
        next_cycle();
        drive(32'h0000_0000, T_IDLE);
        hreadyout_s[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            mid();
            if (k == 19) begin
                check("nowd_stall_hready", 32'(hready), 32'h0);
                check("nowd_tflag", 32'(timeout_flag), 32'h0);
            end
            next_cycle();
        end
        hreadyout_s[1] = 1'b1;
        mid();
        check("nowd_release_hready", 32'(hready), 32'h1);
        check("nowd_err_count", 32'(err_count), 32'd0);
`endif
        next_cycle();
        mid();
        check("end_queue_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_interconnect_n.md
# ahb_interconnect_n

Parametrised AHB-Lite single-master interconnect: decodes HADDR into NUM_SLAVES one-hot selects, registers the address-phase selection into the data phase, and multiplexes the selected slave's HRDATA/HREADYOUT/HRESP back to the master. Unmapped accesses go to a built-in default slave that issues the two-cycle AHB ERROR response. A saturating error counter is provided, plus an optional watchdog for hung slaves. Sits between the master port and the peripheral slave interfaces (register file, GPIO, timer, future slaves).

## Interface
- NUM_SLAVES, 4: number of attached slaves, 1..2^SEL_BITS
- DATA_W, 32: data bus width
- SEL_LSB, 16: lowest HADDR bit of the slave index field; each region is 2^SEL_LSB bytes
- SEL_BITS, 4: width of the slave index field HADDR[SEL_LSB+SEL_BITS-1:SEL_LSB]
- TIMEOUT_CYCLES, 256: watchdog limit (used only with the watchdog compiled in)

- HCLK  in  1  clock, rising edge
- HRESET  in  1  reset, synchronous, active-high
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type
- HSEL_S  out  NUM_SLAVES  one-hot address-phase slave selects
- HRDATA_S  in  NUM_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
- HREADYOUT_S  in  NUM_SLAVES  slave ready outputs
- HRESP_S  in  NUM_SLAVES  slave responses (1 = ERROR)
- HRDATA  out  DATA_W  read data to master
- HREADY  out  1  ready to master; also fanned out to all slaves as HREADYIN
- HRESP  out  1  response to master
- err_count  out  8  saturating count of ERROR responses completed to master
- timeout_flag  out  1  sticky, set on watchdog expiry (tied 0 when watchdog compiled out)

## Operation
- Decode (combinational): idx = HADDR[SEL_LSB+SEL_BITS-1:SEL_LSB]; HSEL_S[idx]=1 if idx<NUM_SLAVES, else all zero. Upper address bits ignored. HSEL_S is independent of HTRANS; slaves qualify with HTRANS.
- Data-phase register: on HCLK where HREADY=1, capture dp_idx<=idx, dp_valid<=HTRANS[1], dp_unmapped<=(idx>=NUM_SLAVES). Not updated while HREADY=0.
- Return mux: mapped data phase → HRDATA/HREADY/HRESP follow slave dp_idx. Unmapped or no data phase → HRDATA=0.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADY=1, HRESP=0. HREADY=1 and HTRANS[1]=1 and idx unmapped → ERR1.
  - ERR1: HREADY=0, HRESP=1 → ERR2.
  - ERR2: HREADY=1, HRESP=1 → IDLE, or ERR1 directly if a new unmapped NONSEQ/SEQ is sampled this cycle.
  - IDLE/BUSY to unmapped addresses: zero-wait OKAY, no FSM entry.
- err_count increments by 1 on every cycle where HREADY=1 and HRESP=1 (default slave or slave-sourced ERROR); saturates at 255.

## Timing
- Reset values: HREADY=1, HRESP=0, HRDATA=0, err_count=0, timeout_flag=0, FSM=IDLE, dp_valid=0, watchdog=0. HSEL_S follows HADDR combinationally even during reset.
- Decode-to-HSEL_S: 0 cycles. Address-to-data-phase mux: 1 cycle after HREADY=1.
- Slave wait states pass through unchanged; the data-phase select is held for their whole duration.
- Default-slave ERROR: exactly 2 data-phase cycles.
- Reset mid-transfer (including ERR1/ERR2 or a slave wait state): next cycle returns to reset values; the pending transfer is dropped.

## Configuration
- AHB_IC_WATCHDOG_EN defined: a 16-bit counter counts consecutive cycles with a mapped valid data phase and HREADYOUT_S[dp_idx]=0. On reaching TIMEOUT_CYCLES, the interconnect stops following the slave, enters ERR1 then ERR2 (master sees the two-cycle ERROR), and sets timeout_flag (cleared only by HRESET). Counter clears whenever HREADY=1.
- Not defined: no counter; timeout_flag tied 0; a slave may stall indefinitely.

## Test plan
- NUM_SLAVES=3, SEL_BITS=2: NONSEQ read 0x0001_0004 → HSEL_S=3'b010; next cycle HRDATA=HRDATA_S slice 1 (0xA5A5_0001), HREADY=1, HRESP=0.
- Slave 2 holds HREADYOUT low 3 cycles while master drives NONSEQ 0x0000_0000 → HSEL_S=3'b001 throughout; HREADY=0 for 3 cycles; returned data from slave 2; slave 0 data phase starts after.
- NONSEQ to 0x0003_0000 (idx 3, unmapped) → HREADY=0/HRESP=1, then HREADY=1/HRESP=1; err_count 0→1.
- IDLE to 0x0003_0000 → HREADY=1, HRESP=0, err_count unchanged.
- Watchdog on, TIMEOUT_CYCLES=16: slave 1 stalls 20 cycles → ERR1 after the 16th stall cycle, ERR2 next, timeout_flag=1, err_count+1.
- HRESET asserted in ERR1 → next cycle HREADY=1, HRESP=0, err_count=0.
